// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the N-digit BCD counter.
//   bcd_t         : one 4-bit BCD decade
//   BCD_MAX/MIN   : largest / smallest legal decade value
//   bcd_is_valid  : true when a nibble holds a legal BCD digit (0..9)
package bcd_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;
    localparam bcd_t BCD_MIN = 4'd0;

    function automatic logic bcd_is_valid(input bcd_t d);
        return (d <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade of the counter.
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset, clears the digit
//   step_in    : advance this decade one step this cycle
//   up         : 1 = increment, 0 = decrement
//   load       : parallel load of load_digit (already validated by the top)
//   load_digit : value to load
//   digit      : registered decade value
//   term       : decade is at its terminal value for the current direction
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       step_in,
    input  logic       up,
    input  logic       load,
    input  logic [3:0] load_digit,
    output logic [3:0] digit,
    output logic       term
);

    bcd_t digit_d;
    bcd_t digit_q;

    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = load_digit;
        end else if (step_in) begin
            if (up) begin
                digit_d = (digit_q == BCD_MAX) ? BCD_MIN : digit_q + 4'd1;
            end else begin
                digit_d = (digit_q == BCD_MIN) ? BCD_MAX : digit_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digit_q <= BCD_MIN;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit = digit_q;
    assign term  = up ? (digit_q == BCD_MAX) : (digit_q == BCD_MIN);

endmodule

// File: rtl/bcd_counter_ndigit.sv
// N-digit up/down BCD counter with parallel load and wrap/saturate option.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset (num = 0, load_err = 0)
//   en       : count enable, one step per enabled cycle
//   up       : direction, 1 = increment, 0 = decrement
//   load     : parallel load request (wins over en)
//   load_val : BCD load value, digit 0 in [3:0]
//   num      : registered count, digit k in [4k+3:4k]
//   co       : combinational carry/borrow-out at terminal count while counting
//   load_err : registered, high for one cycle after a load with a non-BCD nibble
module bcd_counter_ndigit
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 3,
    parameter bit          WRAP   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   num,
    output logic                  co,
    output logic                  load_err
);

    logic [DIGITS-1:0] term;
    logic [DIGITS-1:0] step_chain;
    logic              load_ok;
    logic              all_term;
    logic              count_en;
    logic              digit_load;
    logic              load_err_d;
    logic              load_err_q;

    always_comb begin
        load_ok = 1'b1;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (!bcd_is_valid(load_val[4*k +: 4])) begin
                load_ok = 1'b0;
            end
        end
    end

    assign all_term   = &term;
    // Saturation: at terminal count without wrap, no decade may step.
    assign count_en   = en & ~load & (WRAP | ~all_term);
    // A rejected load still blocks counting (count_en uses raw load).
    assign digit_load = load & load_ok;
    assign co         = en & ~load & ~rst & all_term;

    // Decade k steps only when every lower decade is at its terminal value.
    always_comb begin
        step_chain[0] = count_en;
        for (int unsigned k = 1; k < DIGITS; k++) begin
            step_chain[k] = step_chain[k-1] & term[k-1];
        end
    end

    assign load_err_d = load & ~load_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            load_err_q <= 1'b0;
        end else begin
            load_err_q <= load_err_d;
        end
    end

    assign load_err = load_err_q;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk        (clk),
            .rst        (rst),
            .step_in    (step_chain[g]),
            .up         (up),
            .load       (digit_load),
            .load_digit (load_val[4*g +: 4]),
            .digit      (num[4*g +: 4]),
            .term       (term[g])
        );
    end

endmodule

// File: tb/tb_bcd_counter_ndigit.sv
module tb_bcd_counter_ndigit;

    localparam int DIGITS = 3;
    localparam int W      = 4 * DIGITS;
    localparam int MAXV   = 999;

    logic         clk;
    logic         rst;
    logic         en;
    logic         up;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] num_w, num_s;
    logic         co_w, co_s;
    logic         err_w, err_s;

    // index 0: wrapping instance, index 1: saturating instance
    int           m_val [2];
    logic [W-1:0] obs_num [2];
    logic [W-1:0] exp_num [2];
    logic         obs_co  [2];
    logic         exp_co  [2];
    logic         obs_err [2];
    logic         exp_err;

    int n_checks;
    int n_fail;

    bcd_counter_ndigit #(.DIGITS(DIGITS), .WRAP(1'b1)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val), .num(num_w), .co(co_w), .load_err(err_w)
    );

    bcd_counter_ndigit #(.DIGITS(DIGITS), .WRAP(1'b0)) u_sat (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val), .num(num_s), .co(co_s), .load_err(err_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit bcd_ok(input logic [W-1:0] v);
        for (int k = 0; k < DIGITS; k++) begin
            if (((v >> (4*k)) & 15) > 9) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int bcd_to_int(input logic [W-1:0] v);
        int s = 0;
        int scale = 1;
        for (int k = 0; k < DIGITS; k++) begin
            s += int'((v >> (4*k)) & 15) * scale;
            scale *= 10;
        end
        return s;
    endfunction

    function automatic logic [W-1:0] int_to_bcd(input int n);
        logic [W-1:0] r = '0;
        int x = n;
        for (int k = 0; k < DIGITS; k++) begin
            r |= W'(x % 10) << (4*k);
            x /= 10;
        end
        return r;
    endfunction

    // Applies the currently driven inputs for one clock: samples co before
    // the edge, advances the arithmetic model, samples registers after it.
    task automatic tick();
        bit ok;
        #2;
        obs_co[0] = co_w;
        obs_co[1] = co_s;
        ok = bcd_ok(load_val);
        for (int i = 0; i < 2; i++) begin
            exp_co[i] = !rst && !load && en && (up ? (m_val[i] == MAXV) : (m_val[i] == 0));
            if (rst) begin
                m_val[i] = 0;
            end else if (load) begin
                if (ok) m_val[i] = bcd_to_int(load_val);
            end else if (en) begin
                if (up) m_val[i] = (m_val[i] == MAXV) ? ((i == 0) ? 0 : MAXV) : m_val[i] + 1;
                else    m_val[i] = (m_val[i] == 0) ? ((i == 0) ? MAXV : 0) : m_val[i] - 1;
            end
            exp_num[i] = int_to_bcd(m_val[i]);
        end
        exp_err = !rst && load && !ok;
        @(posedge clk);
        #1;
        obs_num[0] = num_w;
        obs_num[1] = num_s;
        obs_err[0] = err_w;
        obs_err[1] = err_s;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; up = 1'b1; load = 1'b1; load_val = 12'h777;
        tick();
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs_num[i] !== 12'h000) begin
                n_fail++; $display("FAIL reset_num dut%0d: got %h expected 000", i, obs_num[i]);
            end
            n_checks++;
            if (obs_err[i] !== 1'b0) begin
                n_fail++; $display("FAIL reset_err dut%0d: got %b expected 0", i, obs_err[i]);
            end
            n_checks++;
            if (obs_co[i] !== 1'b0) begin
                n_fail++; $display("FAIL reset_co dut%0d: got %b expected 0", i, obs_co[i]);
            end
        end
        rst = 1'b0; load = 1'b0; en = 1'b0;
    endtask

    task automatic test_count_up();
        rst = 1'b1; load = 1'b0; en = 1'b0;
        tick();
        rst = 1'b0; en = 1'b1; up = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (obs_num[i] !== exp_num[i]) begin
                    n_fail++; $display("FAIL up_num dut%0d cyc %0d: got %h expected %h", i, c, obs_num[i], exp_num[i]);
                end
                n_checks++;
                if (obs_co[i] !== exp_co[i]) begin
                    n_fail++; $display("FAIL up_co dut%0d cyc %0d: got %b expected %b", i, c, obs_co[i], exp_co[i]);
                end
            end
        end
        n_checks++;
        if (num_w !== 12'h000) begin
            n_fail++; $display("FAIL up_wrap_end: got %h expected 000", num_w);
        end
        en = 1'b0;
    endtask

    task automatic test_count_down();
        load = 1'b1; load_val = 12'h120; en = 1'b0;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b0;
        for (int c = 0; c < 121; c++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (obs_num[i] !== exp_num[i]) begin
                    n_fail++; $display("FAIL down_num dut%0d cyc %0d: got %h expected %h", i, c, obs_num[i], exp_num[i]);
                end
                n_checks++;
                if (obs_co[i] !== exp_co[i]) begin
                    n_fail++; $display("FAIL down_co dut%0d cyc %0d: got %b expected %b", i, c, obs_co[i], exp_co[i]);
                end
            end
        end
        n_checks++;
        if (num_w !== 12'h999) begin
            n_fail++; $display("FAIL down_wrap_end: got %h expected 999", num_w);
        end
        en = 1'b0;
    endtask

    task automatic test_saturate();
        load = 1'b1; load_val = 12'h998; en = 1'b0;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (obs_num[1] !== 12'h999) begin
                n_fail++; $display("FAIL sat_num cyc %0d: got %h expected 999", c, obs_num[1]);
            end
            n_checks++;
            if (obs_co[1] !== (c != 0)) begin
                n_fail++; $display("FAIL sat_co cyc %0d: got %b expected %b", c, obs_co[1], (c != 0));
            end
            n_checks++;
            if (obs_num[0] !== exp_num[0]) begin
                n_fail++; $display("FAIL sat_wrap_num cyc %0d: got %h expected %h", c, obs_num[0], exp_num[0]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_bad_load();
        load = 1'b1; load_val = 12'h042; en = 1'b0;
        tick();
        load_val = 12'h1A5; en = 1'b1; up = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs_num[i] !== 12'h042) begin
                n_fail++; $display("FAIL badload_num dut%0d: got %h expected 042", i, obs_num[i]);
            end
            n_checks++;
            if (obs_err[i] !== 1'b1) begin
                n_fail++; $display("FAIL badload_err dut%0d: got %b expected 1", i, obs_err[i]);
            end
        end
        load = 1'b0; en = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs_err[i] !== 1'b0) begin
                n_fail++; $display("FAIL badload_err_clear dut%0d: got %b expected 0", i, obs_err[i]);
            end
            n_checks++;
            if (obs_num[i] !== 12'h042) begin
                n_fail++; $display("FAIL badload_hold dut%0d: got %h expected 042", i, obs_num[i]);
            end
        end
    endtask

    task automatic test_reset_over_load();
        load = 1'b1; load_val = 12'h500; en = 1'b0;
        tick();
        rst = 1'b1; load_val = 12'h777; en = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs_num[i] !== 12'h000 || obs_err[i] !== 1'b0) begin
                n_fail++; $display("FAIL rst_load dut%0d: got num %h err %b expected 000 0", i, obs_num[i], obs_err[i]);
            end
        end
        rst = 1'b0; load = 1'b0; en = 1'b1; up = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs_num[i] !== 12'h001) begin
                n_fail++; $display("FAIL rst_resume dut%0d: got %h expected 001", i, obs_num[i]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_direction();
        logic [W-1:0] want [3];
        want[0] = 12'h100; want[1] = 12'h099; want[2] = 12'h300;
        load = 1'b1; load_val = 12'h099; en = 1'b0;
        tick();
        for (int s = 0; s < 3; s++) begin
            load = (s == 2); load_val = 12'h300; en = 1'b1; up = (s == 0);
            tick();
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (obs_num[i] !== want[s]) begin
                    n_fail++; $display("FAIL dir_step%0d dut%0d: got %h expected %h", s, i, obs_num[i], want[s]);
                end
            end
        end
        load = 1'b0; en = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            rst  = ($urandom_range(0, 49) == 0);
            load = ($urandom_range(0, 14) == 0);
            if ($urandom_range(0, 1) == 1) load_val = int_to_bcd(int'($urandom_range(0, MAXV)));
            else                           load_val = W'($urandom());
            en   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) up = ~up;
            tick();
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (obs_num[i] !== exp_num[i] || obs_co[i] !== exp_co[i] || obs_err[i] !== exp_err) begin
                    n_fail++;
                    $display("FAIL rand dut%0d cyc %0d: got num %h co %b err %b expected num %h co %b err %b",
                             i, c, obs_num[i], obs_co[i], obs_err[i], exp_num[i], exp_co[i], exp_err);
                end
            end
        end
        rst = 1'b0; load = 1'b0; en = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_val[0] = 0;
        m_val[1] = 0;
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_count_up();
        test_count_down();
        test_saturate();
        test_bad_load();
        test_reset_over_load();
        test_direction();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
